// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit -- LA32 control/status register file (writeback-stage side)
//
// Accepts CSR reads/writes, exception commits and ERTN commits from the
// writeback stage. Provides the exception-entry / ERTN-return targets for the
// fetch redirect and the interrupt-pending flag for decode. Also contains the
// constant-frequency timer (TCFG/TVAL/TICLR) and samples the external
// interrupt lines into ESTAT.IS every cycle.
//
// Ports:
//   clk          core clock
//   reset        asynchronous active-high reset
//   csr_num      CSR address (read and write)
//   csr_we       write strobe, already qualified by writeback valid
//   csr_wmask    per-bit write enable
//   csr_wvalue   write data
//   wb_exc       exception commit
//   wb_ertn      ERTN commit
//   wb_ecode     exception code
//   wb_esubcode  exception subcode
//   wb_pc        PC of the committing instruction
//   wb_vaddr     faulting data address
//   hw_int_in    external hardware interrupt levels
//   ipi_int_in   inter-processor interrupt level
//   csr_rvalue   combinational read data for csr_num
//   ex_entry     exception target (EENTRY)
//   ertn_entry   return target (ERA)
//   has_int      an enabled interrupt is pending
// ---------------------------------------------------------------------------
module csr_unit #(
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_exc,
  input  logic        wb_ertn,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] csr_rvalue,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_SAVE1  = 14'h031;
  localparam logic [13:0] ADDR_SAVE2  = 14'h032;
  localparam logic [13:0] ADDR_SAVE3  = 14'h033;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;

  localparam logic [5:0]  ECODE_ADEF  = 6'h08;
  localparam logic [5:0]  ECODE_ALE   = 6'h09;

  // Register state
  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;     // bit 10 is reserved and held at 0
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer;
  logic        is_ipi;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry_va;
  logic [31:0] save0, save1, save2, save3;
  logic [31:0] tid;
  logic        tcfg_en;
  logic        tcfg_periodic;
  logic [29:0] tcfg_initval;
  logic [31:0] tval;

  // Assembled register views
  logic [31:0] crmd_view;
  logic [31:0] prmd_view;
  logic [31:0] ecfg_view;
  logic [12:0] estat_is;
  logic [31:0] estat_view;
  logic [31:0] eentry_view;
  logic [31:0] tcfg_view;

  assign crmd_view   = {27'b0, 1'b0, 1'b1, crmd_ie, crmd_plv};   // PG=0, DA=1
  assign prmd_view   = {29'b0, prmd_pie, prmd_pplv};
  assign ecfg_view   = {19'b0, ecfg_lie};
  assign estat_is    = {is_ipi, is_timer, 1'b0, is_hw, is_sw};
  assign estat_view  = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
  assign eentry_view = {eentry_va, 6'b0};
  assign tcfg_view   = {tcfg_initval, tcfg_periodic, tcfg_en};

  // An exception commit suppresses any CSR write in the same cycle.
  logic csr_wr;
  assign csr_wr = csr_we & ~wb_exc;

  logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;
  logic wr_save0, wr_save1, wr_save2, wr_save3, wr_tid, wr_tcfg, wr_ticlr;

  assign wr_crmd   = csr_wr && (csr_num == ADDR_CRMD);
  assign wr_prmd   = csr_wr && (csr_num == ADDR_PRMD);
  assign wr_ecfg   = csr_wr && (csr_num == ADDR_ECFG);
  assign wr_estat  = csr_wr && (csr_num == ADDR_ESTAT);
  assign wr_era    = csr_wr && (csr_num == ADDR_ERA);
  assign wr_badv   = csr_wr && (csr_num == ADDR_BADV);
  assign wr_eentry = csr_wr && (csr_num == ADDR_EENTRY);
  assign wr_save0  = csr_wr && (csr_num == ADDR_SAVE0);
  assign wr_save1  = csr_wr && (csr_num == ADDR_SAVE1);
  assign wr_save2  = csr_wr && (csr_num == ADDR_SAVE2);
  assign wr_save3  = csr_wr && (csr_num == ADDR_SAVE3);
  assign wr_tid    = csr_wr && (csr_num == ADDR_TID);
  assign wr_tcfg   = csr_wr && (csr_num == ADDR_TCFG);
  assign wr_ticlr  = csr_wr && (csr_num == ADDR_TICLR);

  // Masked-merge helper: new = (mask & value) | (~mask & old)
  function automatic logic [31:0] merge(input logic [31:0] mask,
                                        input logic [31:0] value,
                                        input logic [31:0] old);
    return (mask & value) | (~mask & old);
  endfunction

  logic [31:0] crmd_merged, prmd_merged, ecfg_merged, estat_merged;
  logic [31:0] eentry_merged, tcfg_merged;

  assign crmd_merged   = merge(csr_wmask, csr_wvalue, crmd_view);
  assign prmd_merged   = merge(csr_wmask, csr_wvalue, prmd_view);
  assign ecfg_merged   = merge(csr_wmask, csr_wvalue, ecfg_view);
  assign estat_merged  = merge(csr_wmask, csr_wvalue, estat_view);
  assign eentry_merged = merge(csr_wmask, csr_wvalue, eentry_view);
  assign tcfg_merged   = merge(csr_wmask, csr_wvalue, tcfg_view);

  // CRMD / PRMD: exception beats ERTN, ERTN beats a CSR write to CRMD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_plv  <= 2'b0;
      crmd_ie   <= 1'b0;
      prmd_pplv <= 2'b0;
      prmd_pie  <= 1'b0;
    end else begin
      if (wb_exc) begin
        crmd_plv <= 2'b0;
        crmd_ie  <= 1'b0;
      end else if (wb_ertn) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (wr_crmd) begin
        crmd_plv <= crmd_merged[1:0];
        crmd_ie  <= crmd_merged[2];
      end

      if (wb_exc) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
      end else if (wr_prmd) begin
        prmd_pplv <= prmd_merged[1:0];
        prmd_pie  <= prmd_merged[2];
      end
    end
  end

  // ECFG
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecfg_lie <= 13'b0;
    end else if (wr_ecfg) begin
      ecfg_lie <= ecfg_merged[12:0] & 13'h1BFF;
    end
  end

  // Timer events
  logic timer_hit;
  logic ticlr_clr;
  assign timer_hit = tcfg_en && (tval == 32'h0);
  assign ticlr_clr = wr_ticlr && csr_wmask[0] && csr_wvalue[0];

  // ESTAT: interrupt lines sampled every cycle; timer set beats TICLR clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_sw          <= 2'b0;
      is_hw          <= 8'b0;
      is_timer       <= 1'b0;
      is_ipi         <= 1'b0;
      estat_ecode    <= 6'b0;
      estat_esubcode <= 9'b0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wr_estat) begin
        is_sw <= estat_merged[1:0];
      end
      if (timer_hit) begin
        is_timer <= 1'b1;
      end else if (ticlr_clr) begin
        is_timer <= 1'b0;
      end
      if (wb_exc) begin
        estat_ecode    <= wb_ecode;
        estat_esubcode <= wb_esubcode;
      end
    end
  end

  // ERA / BADV / EENTRY / SAVE / TID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      era       <= 32'b0;
      badv      <= 32'b0;
      eentry_va <= 26'b0;
      save0     <= 32'b0;
      save1     <= 32'b0;
      save2     <= 32'b0;
      save3     <= 32'b0;
      tid       <= CORE_ID;
    end else begin
      if (wb_exc) begin
        era <= wb_pc;
      end else if (wr_era) begin
        era <= merge(csr_wmask, csr_wvalue, era);
      end

      // Only address-type exceptions capture a bad address.
      if (wb_exc) begin
        if (wb_ecode == ECODE_ADEF) begin
          badv <= wb_pc;
        end else if (wb_ecode == ECODE_ALE) begin
          badv <= wb_vaddr;
        end
      end else if (wr_badv) begin
        badv <= merge(csr_wmask, csr_wvalue, badv);
      end

      if (wr_eentry) eentry_va <= eentry_merged[31:6];
      if (wr_save0)  save0 <= merge(csr_wmask, csr_wvalue, save0);
      if (wr_save1)  save1 <= merge(csr_wmask, csr_wvalue, save1);
      if (wr_save2)  save2 <= merge(csr_wmask, csr_wvalue, save2);
      if (wr_save3)  save3 <= merge(csr_wmask, csr_wvalue, save3);
      if (wr_tid)    tid   <= merge(csr_wmask, csr_wvalue, tid);
    end
  end

  // Timer: a TCFG write reloads TVAL and suppresses that cycle's tick.
  // All-ones is the "expired" state of a one-shot timer and never ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg_en       <= 1'b0;
      tcfg_periodic <= 1'b0;
      tcfg_initval  <= 30'b0;
      tval          <= 32'hFFFF_FFFF;
    end else if (wr_tcfg) begin
      tcfg_en       <= tcfg_merged[0];
      tcfg_periodic <= tcfg_merged[1];
      tcfg_initval  <= tcfg_merged[31:2];
      tval          <= {tcfg_merged[31:2], 2'b00};
    end else if (tcfg_en && (tval != 32'hFFFF_FFFF)) begin
      if ((tval == 32'h0) && tcfg_periodic) begin
        tval <= {tcfg_initval, 2'b00};
      end else begin
        tval <= tval - 32'h1;
      end
    end
  end

  // Combinational read mux; unmapped addresses and TICLR read 0.
  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      ADDR_CRMD:   csr_rvalue = crmd_view;
      ADDR_PRMD:   csr_rvalue = prmd_view;
      ADDR_ECFG:   csr_rvalue = ecfg_view;
      ADDR_ESTAT:  csr_rvalue = estat_view;
      ADDR_ERA:    csr_rvalue = era;
      ADDR_BADV:   csr_rvalue = badv;
      ADDR_EENTRY: csr_rvalue = eentry_view;
      ADDR_SAVE0:  csr_rvalue = save0;
      ADDR_SAVE1:  csr_rvalue = save1;
      ADDR_SAVE2:  csr_rvalue = save2;
      ADDR_SAVE3:  csr_rvalue = save3;
      ADDR_TID:    csr_rvalue = tid;
      ADDR_TCFG:   csr_rvalue = tcfg_view;
      ADDR_TVAL:   csr_rvalue = tval;
      default:     csr_rvalue = 32'h0;
    endcase
  end

  assign ex_entry   = eentry_view;
  assign ertn_entry = era;
  assign has_int    = crmd_ie & (|(estat_is & ecfg_lie));

endmodule
